// File: rtl/fg_bbox_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fg_bbox_tracker_pkg
//  Description : Shared definitions for the foreground bounding-box tracker:
//                tracker state encoding, default window geometry and the
//                widths of screen counters, window coordinates and counts.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package fg_bbox_tracker_pkg;

    // Widths
    localparam int c_cnt_w   = 31;  // screen hCounter / vCounter
    localparam int c_coord_w = 8;   // window-local x / y
    localparam int c_count_w = 15;  // foreground pixel count

    // Default foreground-window size
    localparam int c_def_win_w = 160;
    localparam int c_def_win_h = 140;

    // Tracker state encoding
    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_wait_frame = 2'd1;
    localparam logic [1:0] c_st_accumulate = 2'd2;
    localparam logic [1:0] c_st_publish    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE             = c_st_idle,
        ST_WAIT_4_NEW_FRAME = c_st_wait_frame,
        ST_ACCUMULATE       = c_st_accumulate,
        ST_PUBLISH          = c_st_publish
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [c_count_w-1:0] sat_inc(input logic [c_count_w-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fg_bbox_tracker_coord_delay.sv
`default_nettype none
// ============================================================================
//  Module      : coord_delay
//  Description : DEPTH-stage register pipeline for the screen counters, so
//                that the counters line up with the foreground-mask bit that
//                was fetched using them DEPTH cycles earlier.
//  Ports       : clk, reset        - clock, asynchronous active-high reset
//                h_in, v_in        - live screen counters
//                h_out, v_out      - counters delayed by DEPTH cycles
//  Revision    : 1.0  initial release
// ============================================================================
module coord_delay
    import fg_bbox_tracker_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [c_cnt_w-1:0] h_in,
    input  logic [c_cnt_w-1:0] v_in,
    output logic [c_cnt_w-1:0] h_out,
    output logic [c_cnt_w-1:0] v_out
);

    // All-ones lies far outside any window, so a freshly reset pipeline
    // can never be mistaken for a window pixel.
    localparam logic [c_cnt_w-1:0] c_sentinel = '1;

    logic [DEPTH-1:0][c_cnt_w-1:0] r_h;
    logic [DEPTH-1:0][c_cnt_w-1:0] r_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= {DEPTH{c_sentinel}};
            r_v <= {DEPTH{c_sentinel}};
        end else begin
            r_h[0] <= h_in;
            r_v[0] <= v_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_h[i] <= r_h[i-1];
                r_v[i] <= r_v[i-1];
            end
        end
    end

    assign h_out = r_h[DEPTH-1];
    assign v_out = r_v[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fg_bbox_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : fg_bbox_tracker
//  Description : Tracks the bounding box and pixel count of the foreground
//                mask inside a fixed screen window, one result per frame.
//  Ports       : clk, reset              - clock, async active-high reset
//                enable                  - tracking enable (level)
//                hCounter_in/vCounter_in - screen column / line counters
//                fg_in                   - mask bit, FG_LAT cycles behind
//                x_min/x_max/y_min/y_max - window-local box of last frame
//                fg_count                - foreground count of last frame
//                bbox_valid              - box holds a qualified result
//                frame_done              - one-cycle pulse on result update
//  Revision    : 1.0  initial release
// ============================================================================
module fg_bbox_tracker
    import fg_bbox_tracker_pkg::*;
#(
    parameter int H_OFF     = 340,
    parameter int V_OFF     = 0,
    parameter int WIN_W     = c_def_win_w,
    parameter int WIN_H     = c_def_win_h,
    parameter int FG_LAT    = 1,
    parameter int MIN_COUNT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [c_cnt_w-1:0]   hCounter_in,
    input  logic [c_cnt_w-1:0]   vCounter_in,
    input  logic                 fg_in,
    output logic [c_coord_w-1:0] x_min,
    output logic [c_coord_w-1:0] x_max,
    output logic [c_coord_w-1:0] y_min,
    output logic [c_coord_w-1:0] y_max,
    output logic [c_count_w-1:0] fg_count,
    output logic                 bbox_valid,
    output logic                 frame_done
);

    localparam logic [c_cnt_w-1:0]   c_h_off     = c_cnt_w'(H_OFF);
    localparam logic [c_cnt_w-1:0]   c_v_off     = c_cnt_w'(V_OFF);
    localparam logic [c_cnt_w-1:0]   c_win_w     = c_cnt_w'(WIN_W);
    localparam logic [c_cnt_w-1:0]   c_win_h     = c_cnt_w'(WIN_H);
    localparam logic [c_coord_w-1:0] c_x_last    = c_coord_w'(WIN_W - 1);
    localparam logic [c_coord_w-1:0] c_y_last    = c_coord_w'(WIN_H - 1);
    localparam logic [c_count_w-1:0] c_min_count = c_count_w'(MIN_COUNT);

    logic [c_cnt_w-1:0]   w_h_dly, w_v_dly, w_h_rel, w_v_rel;
    logic [c_coord_w-1:0] w_x, w_y;
    logic                 w_in_win, w_first, w_last, w_hit;
    logic                 w_load, w_accum, w_publish, w_qualified;

    state_t r_state, w_state_nxt;

    logic [c_coord_w-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
    logic [c_count_w-1:0] r_cnt;

    coord_delay #(
        .DEPTH (FG_LAT)
    ) u_coord_delay (
        .clk   (clk),
        .reset (reset),
        .h_in  (hCounter_in),
        .v_in  (vCounter_in),
        .h_out (w_h_dly),
        .v_out (w_v_dly)
    );

    // Window test on the delayed counters; the subtraction wraps for
    // counters left of/above the window, hence the separate >= checks.
    assign w_h_rel  = w_h_dly - c_h_off;
    assign w_v_rel  = w_v_dly - c_v_off;
    assign w_in_win = (w_h_dly >= c_h_off) && (w_h_rel < c_win_w) &&
                      (w_v_dly >= c_v_off) && (w_v_rel < c_win_h);
    assign w_x      = w_h_rel[c_coord_w-1:0];
    assign w_y      = w_v_rel[c_coord_w-1:0];
    assign w_first  = w_in_win && (w_x == '0) && (w_y == '0);
    assign w_last   = w_in_win && (w_x == c_x_last) && (w_y == c_y_last);
    assign w_hit    = w_in_win && fg_in;

    // A window origin seen in any tracking state starts a fresh frame; in
    // ACCUMULATE this also drops a frame whose last pixel never arrived.
    assign w_load    = enable && w_first && (r_state != ST_IDLE);
    assign w_accum   = enable && (r_state == ST_ACCUMULATE) && w_hit && !w_first;
    assign w_publish = enable && (r_state == ST_PUBLISH);
    assign w_qualified = (r_cnt >= c_min_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:             w_state_nxt = ST_WAIT_4_NEW_FRAME;
                ST_WAIT_4_NEW_FRAME: if (w_first) w_state_nxt = ST_ACCUMULATE;
                ST_ACCUMULATE:       if (w_last)  w_state_nxt = ST_PUBLISH;
                ST_PUBLISH:          w_state_nxt = w_first ? ST_ACCUMULATE
                                                           : ST_WAIT_4_NEW_FRAME;
                default:             w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Running box: min starts at all-ones and max at zero so the first
    // foreground pixel overwrites both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
            r_cnt   <= '0;
        end else if (!enable || r_state == ST_IDLE) begin
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_x_min <= fg_in ? w_x : '1;
            r_x_max <= fg_in ? w_x : '0;
            r_y_min <= fg_in ? w_y : '1;
            r_y_max <= fg_in ? w_y : '0;
            r_cnt   <= fg_in ? c_count_w'(1) : '0;
        end else if (w_accum) begin
            if (w_x < r_x_min) r_x_min <= w_x;
            if (w_x > r_x_max) r_x_max <= w_x;
            if (w_y < r_y_min) r_y_min <= w_y;
            if (w_y > r_y_max) r_y_max <= w_y;
            r_cnt <= sat_inc(r_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            fg_count   <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_publish;
            if (w_publish) begin
                fg_count   <= r_cnt;
                bbox_valid <= w_qualified;
                x_min      <= w_qualified ? r_x_min : '0;
                x_max      <= w_qualified ? r_x_max : '0;
                y_min      <= w_qualified ? r_y_min : '0;
                y_max      <= w_qualified ? r_y_max : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fg_bbox_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fg_bbox_tracker
//  Description : Self-checking bench for fg_bbox_tracker on a reduced raster
//                (40x20 screen, 16x12 window at (20,3), FG_LAT=3).
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fg_bbox_tracker;

    localparam int RH   = 40;
    localparam int RV   = 20;
    localparam int HO   = 20;
    localparam int VO   = 3;
    localparam int WW   = 16;
    localparam int WH   = 12;
    localparam int LAT  = 3;
    localparam int MINC = 8;

    localparam int K_NORMAL = 0;
    localparam int K_JUMP   = 1;
    localparam int K_EN     = 2;
    localparam int K_RST    = 3;

    typedef struct packed {
        logic [7:0]  xmn;
        logic [7:0]  xmx;
        logic [7:0]  ymn;
        logic [7:0]  ymx;
        logic [14:0] cnt;
        logic        vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [30:0] hCounter_in;
    logic [30:0] vCounter_in;
    logic        fg_in;
    logic [7:0]  x_min, x_max, y_min, y_max;
    logic [14:0] fg_count;
    logic        bbox_valid;
    logic        frame_done;

    int   checks   = 0;
    int   failures = 0;
    int   n_pushed = 0;
    int   n_done   = 0;
    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    bit   hist[$];
    bit   m  [WH][WW];
    bit   m2 [WH][WW];

    fg_bbox_tracker #(
        .H_OFF     (HO),
        .V_OFF     (VO),
        .WIN_W     (WW),
        .WIN_H     (WH),
        .FG_LAT    (LAT),
        .MIN_COUNT (MINC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .hCounter_in (hCounter_in),
        .vCounter_in (vCounter_in),
        .fg_in       (fg_in),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .fg_count    (fg_count),
        .bbox_valid  (bbox_valid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t act_now();
        exp_t a;
        a.xmn = x_min;  a.xmx = x_max;
        a.ymn = y_min;  a.ymx = y_max;
        a.cnt = fg_count;
        a.vld = bbox_valid;
        return a;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", n, act, exp);
        end
    endtask

    task automatic cmp_t(input string n, input exp_t a, input exp_t e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got box x=%0d..%0d y=%0d..%0d cnt=%0d valid=%0d, want x=%0d..%0d y=%0d..%0d cnt=%0d valid=%0d",
                     n, a.xmn, a.xmx, a.ymn, a.ymx, a.cnt, a.vld,
                     e.xmn, e.xmx, e.ymn, e.ymx, e.cnt, e.vld);
        end
    endtask

    // Reference: the box, count and qualification of a whole mask.
    function automatic exp_t model(input bit use_b);
        exp_t e;
        int cnt = 0, mnx = 255, mxx = 0, mny = 255, mxy = 0;
        bit b;
        for (int y = 0; y < WH; y++) begin
            for (int x = 0; x < WW; x++) begin
                b = use_b ? m2[y][x] : m[y][x];
                if (b) begin
                    cnt++;
                    if (x < mnx) mnx = x;
                    if (x > mxx) mxx = x;
                    if (y < mny) mny = y;
                    if (y > mxy) mxy = y;
                end
            end
        end
        e = '0;
        e.cnt = (cnt > 32767) ? 15'h7fff : 15'(cnt);
        e.vld = (cnt >= MINC);
        if (e.vld) begin
            e.xmn = 8'(mnx); e.xmx = 8'(mxx);
            e.ymn = 8'(mny); e.ymx = 8'(mxy);
        end
        return e;
    endfunction

    task automatic clear_m();
        for (int y = 0; y < WH; y++)
            for (int x = 0; x < WW; x++)
                m[y][x] = 1'b0;
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                m[y][x] = 1'b1;
    endtask

    task automatic rand_m(input int dens);
        for (int y = 0; y < WH; y++)
            for (int x = 0; x < WW; x++)
                m[y][x] = ($urandom_range(0, 99) < dens);
    endtask

    // One raster cycle: present counters, and present the mask bit of the
    // counters issued LAT cycles ago. Outside the window fg is random noise.
    task automatic step(input int h, input int v);
        bit f;
        int x, y;
        x = h - HO;
        y = v - VO;
        if (x >= 0 && x < WW && y >= 0 && y < WH) f = m[y][x];
        else f = 1'($urandom_range(0, 1));
        hist.push_back(f);
        hCounter_in = 31'(h);
        vCounter_in = 31'(v);
        if (hist.size() > LAT) fg_in = hist.pop_front();
        else fg_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int kind, input int arg);
        int v, hs, rst_left;
        bit jumped;
        exp_t e;
        jumped = 0; rst_left = 0; v = 0; hs = 0;
        if (kind == K_NORMAL || kind == K_JUMP) begin
            e = model(kind == K_JUMP);
            sb.push_back(e);
            n_pushed++;
            last = e;
        end
        while (v < RV) begin
            for (int h = hs; h < RH; h++) begin
                if (h == 0 && v == VO + arg) begin
                    if (kind == K_EN) enable = 1'b0;
                    if (kind == K_RST) begin reset = 1'b1; rst_left = 4; end
                end
                step(h, v);
                if (rst_left > 0) begin
                    cmp_t("reset_midframe_outputs", act_now(), '0);
                    chk("reset_midframe_done", int'(frame_done), 0);
                    rst_left--;
                    if (rst_left == 0) begin
                        reset = 1'b0;
                        last  = '0;
                    end
                end
            end
            hs = 0;
            if (kind == K_JUMP && !jumped && v == VO + arg) begin
                jumped = 1;
                m  = m2;
                v  = VO;
                hs = HO;
            end else begin
                v++;
            end
        end
        if (kind == K_EN) begin
            cmp_t("enable_drop_hold", act_now(), last);
            enable = 1'b1;
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && frame_done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done: got pulse with cnt=%0d, want none", fg_count);
            end else begin
                mon_e = sb.pop_front();
                cmp_t("frame_result", act_now(), mon_e);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; fg_in = 1'b0;
        hCounter_in = '0; vCounter_in = '0;
        last = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_t("reset_outputs", act_now(), '0);
        chk("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0; enable = 1'b1;

        clear_m(); rect(3, 6, 2, 5);    run_frame(K_NORMAL, 0); // 16 px box
        clear_m(); rect(0, 4, 7, 7);    run_frame(K_NORMAL, 0); // 5 px, unqualified
        clear_m(); rect(0, WW-1, 0, WH-1); run_frame(K_NORMAL, 0); // full window
        clear_m();                      run_frame(K_NORMAL, 0); // empty frame
        clear_m(); rect(8, 15, 11, 11); run_frame(K_NORMAL, 0); // exactly MINC
        clear_m(); rect(9, 15, 11, 11); run_frame(K_NORMAL, 0); // MINC-1
        clear_m(); m[0][0] = 1'b1; rect(14, 15, 10, 11); run_frame(K_NORMAL, 0);

        // Counters jump back to the window origin after local line 4.
        clear_m(); rect(1, 2, 0, 3); m2 = m;
        rand_m(60);                     run_frame(K_JUMP, 4);
        clear_m(); rect(5, 9, 3, 8);    run_frame(K_NORMAL, 0);

        // Enable dropped at local line 6, then a fresh frame.
        clear_m(); rect(0, WW-1, 0, WH-1); run_frame(K_EN, 6);
        rand_m(40);                     run_frame(K_NORMAL, 0);

        // Reset pulsed at local line 5, then a fresh frame.
        clear_m(); rect(0, WW-1, 0, WH-1); run_frame(K_RST, 5);
        clear_m(); rect(2, 12, 1, 9);   run_frame(K_NORMAL, 0);

        for (int i = 0; i < 10; i++) begin
            rand_m($urandom_range(0, 30));
            run_frame(K_NORMAL, 0);
        end

        for (int i = 0; i < 20; i++) step(0, 0);
        chk("scoreboard_drained", sb.size(), 0);
        chk("frames_published", n_done, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fg_bbox_tracker.md
FG_BBOX_TRACKER -- requirements
Module: fg_bbox_tracker

Interface
REQ-001 Parameter H_OFF, default 340, meaning screen hCounter of foreground-window column 0.
REQ-002 Parameter V_OFF, default 0, meaning screen vCounter of foreground-window row 0.
REQ-003 Parameter WIN_W, default 160, meaning window width in pixels.
REQ-004 Parameter WIN_H, default 140, meaning window height in lines.
REQ-005 Parameter FG_LAT, default 1, range 1..4, meaning cycles fg_in lags the counters that addressed it.
REQ-006 Parameter MIN_COUNT, default 64, meaning minimum foreground pixels for a valid box.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  tracking enable, level.
REQ-010 hCounter_in  input  31  screen column counter.
REQ-011 vCounter_in  input  31  screen line counter.
REQ-012 fg_in  input  1  foreground-mask bit for pixel addressed FG_LAT cycles earlier.
REQ-013 x_min, x_max  output  8 each  window-local box columns, 0..WIN_W-1.
REQ-014 y_min, y_max  output  8 each  window-local box lines, 0..WIN_H-1.
REQ-015 fg_count  output  15  foreground pixel count of last completed frame.
REQ-016 bbox_valid  output  1  box outputs hold a qualified box.
REQ-017 frame_done  output  1  one-cycle pulse when results update.

Function
REQ-018 Counters SHALL pass through an FG_LAT-deep register pipeline; all window decisions use the delayed (h,v) paired with current fg_in.
REQ-019 Delayed pixel in-window iff H_OFF<=h<H_OFF+WIN_W and V_OFF<=v<V_OFF+WIN_H; local x=h-H_OFF, y=v-V_OFF.
REQ-020 States SHALL be IDLE, WAIT_4_NEW_FRAME, ACCUMULATE, PUBLISH.
REQ-021 IDLE -> WAIT_4_NEW_FRAME when enable=1; any state -> IDLE when enable=0, discarding accumulators, outputs held.
REQ-022 WAIT_4_NEW_FRAME -> ACCUMULATE on delayed (x,y)=(0,0); that pixel is accumulated (accumulators initialised from it).
REQ-023 In ACCUMULATE each in-window pixel with fg_in=1 SHALL update running min/max x,y and increment count; out-of-window cycles ignored.
REQ-024 Count SHALL saturate at 32767.
REQ-025 Delayed (x,y)=(WIN_W-1,WIN_H-1) SHALL be accumulated and cause ACCUMULATE -> PUBLISH.
REQ-026 Delayed (0,0) seen in ACCUMULATE (end missed) SHALL restart accumulation from that pixel, no publish.
REQ-027 PUBLISH lasts one cycle: fg_count<=count; frame_done=1; if count>=MIN_COUNT box outputs<=running box, bbox_valid<=1, else box outputs<=0, bbox_valid<=0; next state ACCUMULATE if delayed (x,y)=(0,0) this cycle else WAIT_4_NEW_FRAME.
REQ-028 Empty frame (count 0): running min SHALL be initialised to max value and max to 0, and never exposed unless qualified.
REQ-029 Result latency: outputs update on the edge ending PUBLISH, FG_LAT+2 cycles after the last pixel's counters are presented.

Reset
REQ-030 reset=1 SHALL force state IDLE, delay pipeline to out-of-window sentinel, accumulators cleared, all outputs 0, frame_done 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; tracking resumes at next (0,0) after reset release with enable=1.

Structure
REQ-032 Shared package SHALL hold state encoding constants (IDLE=0, WAIT_4_NEW_FRAME=1, ACCUMULATE=2, PUBLISH=3), default window size, and coordinate/count widths.
REQ-033 Sub-module coord_delay SHALL implement the FG_LAT counter pipeline.

Verification
REQ-034 Raster 800x525, enable=1, fg_in=1 only at local (10..20, 30..40), 121 pixels -> frame_done once, box (10,20,30,40), fg_count=121, bbox_valid=1.
REQ-035 Same raster, 50 fg pixels -> fg_count=50, bbox_valid=0, box outputs 0.
REQ-036 All 22400 window pixels fg -> box (0,159,0,139), fg_count=22400, bbox_valid=1.
REQ-037 Counters jump back to (H_OFF,V_OFF) mid-frame -> no frame_done; next full frame reports only its own pixels.
REQ-038 enable deasserted at local line 70 -> IDLE, no frame_done, outputs unchanged; re-enable -> result from next full frame.
REQ-039 reset pulsed mid-frame, FG_LAT=3 -> all outputs 0 during reset; next frame result correct with 3-cycle alignment.
